// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_scheduler
// Brief    : Register-file write-port owner: x1..x31 clear sweep, WB/MC
//            arbitration with an MC FIFO, and RAW hazard query.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_scheduler #(
   parameter int MC_DEPTH = 2,
   parameter int XLEN     = 32
) (
   input  logic            clk,
   input  logic            srst,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            mc_valid,
   input  logic [4:0]      mc_rd,
   input  logic [XLEN-1:0] mc_data,
   output logic            mc_ready,
   input  logic [4:0]      q_rs1,
   input  logic [4:0]      q_rs2,
   output logic            q_hazard,
   output logic            init_busy,
   output logic            WE3,
   output logic [4:0]      A3,
   output logic [XLEN-1:0] WD3
);

   localparam int PTR_W = $clog2(MC_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [4:0]        r_sweep;
   logic [4:0]        r_fifo_rd   [MC_DEPTH];
   logic [XLEN-1:0]   r_fifo_data [MC_DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_full;
   logic              w_empty;
   logic              w_wb_req;
   logic              w_pop;
   logic              w_push;
   logic              w_haz1;
   logic              w_haz2;

   assign w_full  = (r_count == CNT_W'(MC_DEPTH));
   assign w_empty = (r_count == '0);
   // rd=0 handshakes complete but are dropped, so x0 never reaches the port
   assign w_push  = mc_valid && mc_ready && (mc_rd != 5'd0);

   always_ff @(posedge clk) begin
      if (srst) r_state <= S_INIT;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      init_busy   = 1'b1;
      mc_ready    = 1'b0;
      w_wb_req    = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         S_INIT: begin
            if (r_sweep == 5'd31) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            init_busy = srst;
            mc_ready  = !w_full && !srst;
            w_wb_req  = wb_we && (wb_rd != 5'd0);
            w_pop     = !w_wb_req && !w_empty;
         end
         default: w_state_nxt = S_INIT;
      endcase
   end

   always_comb begin
      logic [PTR_W-1:0] off;
      off    = '0;
      w_haz1 = (q_rs1 != 5'd0) && ((WE3 && (A3 == q_rs1)) || (w_push && (mc_rd == q_rs1)));
      w_haz2 = (q_rs2 != 5'd0) && ((WE3 && (A3 == q_rs2)) || (w_push && (mc_rd == q_rs2)));
      for (int i = 0; i < MC_DEPTH; i++) begin
         off = PTR_W'(i) - r_rptr;
         if ({1'b0, off} < r_count) begin
            if ((q_rs1 != 5'd0) && (r_fifo_rd[i] == q_rs1)) w_haz1 = 1'b1;
            if ((q_rs2 != 5'd0) && (r_fifo_rd[i] == q_rs2)) w_haz2 = 1'b1;
         end
      end
      q_hazard = (w_haz1 || w_haz2) && (r_state == S_RUN) && !srst;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         r_sweep <= 5'd1;
         WE3     <= 1'b0;
         A3      <= 5'd0;
         WD3     <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (r_state == S_INIT) begin
            WE3     <= 1'b1;
            A3      <= r_sweep;
            WD3     <= '0;
            r_sweep <= r_sweep + 5'd1;
         end else if (w_wb_req) begin
            WE3 <= 1'b1;
            A3  <= wb_rd;
            WD3 <= wb_data;
         end else if (w_pop) begin
            WE3 <= 1'b1;
            A3  <= r_fifo_rd[r_rptr];
            WD3 <= r_fifo_data[r_rptr];
         end else begin
            WE3 <= 1'b0;
         end
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset; validity lives in the pointers/count
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_rd[r_wptr]   <= mc_rd;
         r_fifo_data[r_wptr] <= mc_data;
      end
   end

endmodule
`default_nettype wire

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Owns the single write port (WE3/A3/WD3) of the 32x32 integer register file.
- After reset, sweeps x1..x31 to zero, because register storage has no reset.
- In run mode, arbitrates the port between pipeline writeback (WB, fixed priority, never stalled) and a multi-cycle unit (MC: load/div) that is buffered in a small FIFO.
- Exposes a RAW hazard query so decode can stall on registers with writes still queued or in flight.

Parameters:
- MC_DEPTH, 2, MC FIFO entries; power of two, range 2..8.
- XLEN, 32, data width of WD3, wb_data and mc_data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- srst  in  1  synchronous active-high reset.
- wb_we  in  1  WB write request this cycle.
- wb_rd  in  5  WB destination register.
- wb_data  in  XLEN  WB write data.
- mc_valid  in  1  MC write request valid.
- mc_rd  in  5  MC destination register.
- mc_data  in  XLEN  MC write data.
- mc_ready  out  1  MC FIFO can accept; transfer occurs when mc_valid & mc_ready.
- q_rs1  in  5  hazard query, source 1.
- q_rs2  in  5  hazard query, source 2.
- q_hazard  out  1  query hits a pending write.
- init_busy  out  1  clear sweep in progress; the pipeline must be held.
- WE3  out  1  register file write enable (registered).
- A3  out  5  register file write address (registered).
- WD3  out  XLEN  register file write data (registered).

Behaviour:
- Clock and reset: one clock, clk; reset is srst, synchronous, active-high.
- Reset values:
  - WE3=0, A3=0, WD3=0; FIFO empty; state=INIT; sweep counter=1.
  - mc_ready=0, init_busy=1, q_hazard=0 while srst is high.
- FSM, two states:
  - INIT: on each edge with srst=0, register WE3=1, A3=cnt, WD3=0, then cnt++. The edge that issues A3=31 moves to RUN. This gives exactly 31 consecutive WE3 pulses, addresses 1..31 ascending.
  - INIT outputs: init_busy=1 and mc_ready=0. wb_we is ignored.
  - RUN: remains until srst.
- Output timing: the write port is registered. A request selected at edge N appears on WE3/A3/WD3 after edge N and lands in the register file at edge N+1.
- RUN arbitration, evaluated each edge:
  1. If wb_we=1 and wb_rd!=0, issue WB.
  2. Else if the FIFO is non-empty, pop the head and issue it.
  3. Else WE3=0. A3/WD3 hold their last values (don't-care).
- Never issue a write to x0:
  - wb_rd=0 counts as no WB request, so the FIFO may drain that cycle.
  - An MC handshake with mc_rd=0 is accepted and discarded (not enqueued).
- mc_ready = (state==RUN) & !full. It does not depend on a same-cycle pop (no pass-through).
- An enqueue and a pop in the same cycle are legal when not full; occupancy is unchanged.
- FIFO order is strict FIFO; the pointers wrap modulo MC_DEPTH.
- Duplicate rd across WB and FIFO entries is allowed. Final register value follows issue order.
- q_hazard (combinational) is 1 when q_rsX != 0 and q_rsX equals any of:
  - the rd of any valid FIFO entry;
  - A3 while WE3=1 (write in flight);
  - mc_rd while an MC transfer with mc_rd!=0 is occurring this cycle.
  - WB is excluded; forwarding handles it.
  - Forced to 0 in INIT.
- Starvation: a continuous stream of WB writes starves the FIFO. mc_ready then stays 0 once full; this is required, not an error.
- srst mid-operation:
  - All FIFO contents are dropped.
  - Any in-flight WE3 is cleared on that edge.
  - The sweep restarts at x1.

Test Plan:
- Reset pulse, then idle -> init_busy high for 31 cycles; WE3=1 with A3=1..31 ascending, WD3=0; then WE3=0, init_busy=0, mc_ready=1.
- RUN: wb_we=1, wb_rd=5, wb_data=0x5 at edge N, with the FIFO empty -> after N: WE3=1, A3=5, WD3=0x5; the register file holds x5=5 after N+1.
- mc_valid with mc_rd=9, mc_data=0x8 while wb_we=1 to x3 for 3 cycles -> mc_ready stays 1 (the entry queues); x3 writes issue for 3 cycles; x9 issues on the 4th; q_hazard=1 for q_rs1=9 throughout until the write lands.
- MC_DEPTH=2, WB busy every cycle, MC pushes rd 10, 11, 12 -> 10 and 11 accepted; mc_ready=0 with 12 held; when WB idles, issue order is 10, 11, 12.
- MC handshake with mc_rd=0, and wb_we=1 with wb_rd=0 -> no WE3 pulse, FIFO stays empty, q_hazard=0 for q_rs1=0.
- srst asserted with 2 FIFO entries and WE3=1 -> next cycle WE3=0 and the FIFO is empty; the sweep restarts at A3=1; the dropped entries never appear.
